// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the memory-stage data responder: FSM encodings and word geometry.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/data_mem_responder_data_ram_bytewise.sv
// Synchronous single-port word RAM with per-byte write lanes and a registered, write-first read.
module data_ram_bytewise
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [3:0]            byte_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] merged;

    // Old word with the enabled lanes replaced; doubles as the write-first read value.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Array write and registered read port; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= merged;
            rdata     <= merged;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for memory-stage loads/stores: word RAM behind a fixed number of wait states.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | ready; a valid request is accepted and latched on this edge
//  ST_WAIT | counting wait states; pipeline held via stall_m
//  ST_RESP | RAM access committed on entry; resp_valid for one cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_error,
    output logic        stall_m
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic             lat_write;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;

    logic             accept;
    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic             cur_misaligned;
    logic             enter_resp;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic             unused_addr_hi;

    // Reset asserts immediately but releases in step with clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // State and wait counter registers.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and wait counting.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_next   = '0;
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept = (state == ST_IDLE) && req_valid;

    // Request fields are sampled only at the accept edge.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_byte_en;
        end
    end

    // With zero wait states the commit edge is the accept edge, so the live request feeds the RAM in IDLE.
    assign cur_write      = (state == ST_IDLE) ? req_write   : lat_write;
    assign cur_addr       = (state == ST_IDLE) ? req_addr    : lat_addr;
    assign cur_wdata      = (state == ST_IDLE) ? req_wdata   : lat_wdata;
    assign cur_be         = (state == ST_IDLE) ? req_byte_en : lat_be;
    assign cur_misaligned = (cur_addr[1:0] != 2'b00);
    assign unused_addr_hi = ^cur_addr[31:ADDR_WIDTH+2];

    assign enter_resp = (state != ST_RESP) && (state_next == ST_RESP);
    assign ram_we     = rst_int_n && enter_resp && cur_write && !cur_misaligned;

    data_ram_bytewise #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .we      (ram_we),
        .byte_en (cur_be),
        .addr    (cur_addr[ADDR_WIDTH+1:2]),
        .wdata   (cur_wdata),
        .rdata   (ram_rdata)
    );

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign addr_error = resp_valid && (lat_addr[1:0] != 2'b00);
    assign resp_rdata = (resp_valid && !lat_write && !addr_error) ? ram_rdata : 32'h0;
    assign stall_m    = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance 0 has zero wait states, instance 1 has two.
module tb_data_mem_responder;

    localparam int WC0 = 0;
    localparam int WC1 = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        req_valid   [2];
    logic        req_write   [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic [3:0]  req_byte_en [2];
    logic        req_ready   [2];
    logic        resp_valid  [2];
    logic [31:0] resp_rdata  [2];
    logic        addr_error  [2];
    logic        stall_m     [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks;
    int   n_fail;
    longint acc_time [2];

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC0)) u_dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid[0]),
        .req_write   (req_write[0]),
        .req_addr    (req_addr[0]),
        .req_wdata   (req_wdata[0]),
        .req_byte_en (req_byte_en[0]),
        .req_ready   (req_ready[0]),
        .resp_valid  (resp_valid[0]),
        .resp_rdata  (resp_rdata[0]),
        .addr_error  (addr_error[0]),
        .stall_m     (stall_m[0])
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC1)) u_dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid[1]),
        .req_write   (req_write[1]),
        .req_addr    (req_addr[1]),
        .req_wdata   (req_wdata[1]),
        .req_byte_en (req_byte_en[1]),
        .req_ready   (req_ready[1]),
        .resp_valid  (resp_valid[1]),
        .resp_rdata  (resp_rdata[1]),
        .addr_error  (addr_error[1]),
        .stall_m     (stall_m[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input int d);
        exp_t e;
        if (d == 0) begin
            if (exp_q0.size() == 0) begin
                chk("unexpected_resp0", 32'd1, 32'd0);
                return;
            end
            e = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) begin
                chk("unexpected_resp1", 32'd1, 32'd0);
                return;
            end
            e = exp_q1.pop_front();
        end
        chk("resp_rdata", resp_rdata[d], e.rdata);
        chk("addr_error", 32'(addr_error[d]), 32'(e.err));
    endtask

    // Scoreboard side: every response is matched against the oldest pending expectation.
    always @(negedge clock) begin
        if (resp_valid[0] === 1'b1) check_resp(0);
        if (resp_valid[1] === 1'b1) check_resp(1);
    end

    task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   wc;
        bit   seen;
        wc = (d == 0) ? WC0 : WC1;
        @(negedge clock);
        req_write[d]   = wr;
        req_addr[d]    = addr;
        req_wdata[d]   = wdata;
        req_byte_en[d] = be;
        req_valid[d]   = 1'b1;
        #1;
        chk("accept_ready", 32'(req_ready[d]), 32'd1);
        chk("accept_stall", 32'(stall_m[d]), 32'd1);
        @(posedge clock);
        acc_time[d] = $time;
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        #1;
        req_valid[d]   = 1'b0;
        req_write[d]   = ~wr;
        req_addr[d]    = 32'hFFFF_FFFF;
        req_wdata[d]   = $urandom;
        req_byte_en[d] = 4'hF;
        seen = 1'b0;
        for (int k = 1; k <= wc + 4 && !seen; k++) begin
            @(negedge clock);
            if (resp_valid[d] === 1'b1) begin
                seen = 1'b1;
                chk("latency", 32'(k), 32'(wc + 1));
                chk("resp_stall", 32'(stall_m[d]), 32'd0);
                chk("resp_ready", 32'(req_ready[d]), 32'd0);
            end else begin
                chk("wait_stall", 32'(stall_m[d]), 32'd1);
            end
        end
        if (!seen) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t_prev;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]   = 1'b0;
            req_write[d]   = 1'b0;
            req_addr[d]    = '0;
            req_wdata[d]   = '0;
            req_byte_en[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(resp_valid[d]), 32'd0);
            chk("rst_stall", 32'(stall_m[d]), 32'd0);
            chk("rst_rdata", resp_rdata[d], 32'd0);
            chk("rst_err", 32'(addr_error[d]), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Two wait states: store/load, byte lanes, misaligned accesses.
        do_req(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        do_req(1, 1'b1, 32'h80, 32'h11223344, 4'hF, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        do_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        do_req(1, 1'b0, 32'h42, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(1, 1'b1, 32'h41, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Zero wait states: back-to-back accepts every two cycles, read-after-write, address wrap.
        do_req(0, 1'b1, 32'h100, 32'h01020304, 4'hF, 32'h0, 1'b0);
        t_prev = acc_time[0];
        do_req(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h01020304, 1'b0);
        chk("b2b_spacing", 32'(acc_time[0] - t_prev), 32'd20);
        t_prev = acc_time[0];
        do_req(0, 1'b1, 32'h1000, 32'h5A5A0001, 4'hF, 32'h0, 1'b0);
        chk("b2b_spacing", 32'(acc_time[0] - t_prev), 32'd20);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A0001, 1'b0);
        do_req(0, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h1004, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        // Reset during the wait states of a store: no commit, no response.
        do_req(1, 1'b1, 32'h20, 32'hCAFE0020, 4'hF, 32'h0, 1'b0);
        @(negedge clock);
        req_write[1]   = 1'b1;
        req_addr[1]    = 32'h20;
        req_wdata[1]   = 32'h12345678;
        req_byte_en[1] = 4'hF;
        req_valid[1]   = 1'b1;
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clock);
        chk("mid_wait_stall", 32'(stall_m[1]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("mid_rst_stall", 32'(stall_m[1]), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE0020, 1'b0);

        repeat (2) @(negedge clock);
        chk("q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the memory-stage data interface: services load/store requests issued by the pipelined core's memory stage.
- Holds a word-addressed data RAM and inserts a parameterised number of wait states per access.
- Drives stall_m back to the hazard logic while an access is outstanding; returns load data with a one-cycle resp_valid pulse.
- Sits between the memory stage and the writeback path; replaces the zero-latency data memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits (RAM depth = 2**ADDR_WIDTH 32-bit words).
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 allowed).

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  memory stage presents a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALUOutM).
- req_wdata  input  32  store data (WriteDataM).
- req_byte_en  input  4  store byte lanes; bit i enables bits [8i+7:8i]; ignored on loads.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  32  load data, valid only with resp_valid.
- addr_error  output  1  pulses with resp_valid on a misaligned request.
- stall_m  output  1  hold the pipeline; access outstanding.

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; addr_error=0; stall_m follows its equation (0 when req_valid=0). RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/addr/wdata/byte_en and clear the wait counter.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - req_ready=0. The counter increments each cycle.
  - Leave for RESP in the cycle the count reaches WAIT_CYCLES-1.
  - Total latency from the accept edge to resp_valid is WAIT_CYCLES+1 cycles.
- Commit point: the RAM access is performed on the edge entering RESP.
  - Store: write the enabled byte lanes only.
  - Load: capture the full word into resp_rdata.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE. A new request is accepted no earlier than the following cycle.
- stall_m = (state==IDLE && req_valid) || state==WAIT. It is combinational, so it is high in the accept cycle and all wait cycles, and low in RESP so the pipeline advances with the data.
- Store response: resp_rdata=0.
- Misaligned request (req_addr[1:0]!=0):
  - Goes through the normal timing.
  - No RAM write; resp_rdata=0; addr_error=1 alongside resp_valid.
- Address mapping: word index = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM size.
- A load immediately following a store to the same word returns the newly written data, because the write is committed before the load is accepted.
- Reset asserted mid-access: the transaction is dropped.
  - A store not yet at its commit edge leaves the RAM unchanged.
  - No resp_valid is emitted.
- req_valid deasserted in WAIT or RESP has no effect. Request inputs are sampled only at acceptance.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and a constant WORD_BYTES=4.
- One sub-module: data_ram_bytewise.
  - Synchronous single-port RAM.
  - Ports: clock, we, byte_en[3:0], addr[ADDR_WIDTH-1:0], wdata[31:0], rdata[31:0].
  - Registered read; write-first on simultaneous read/write.
- The FSM, counter and response registers live in the top.

Test Plan:
- Reset with req_valid=0: req_ready=1, resp_valid=0, stall_m=0, resp_rdata=0. Assert reset_n=0 asynchronously between clock edges; outputs clear immediately.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x40 with byte_en=4'hF: stall_m high 3 cycles, resp_valid at cycle 3 after accept.
  - Load 0x40: resp_rdata=0xDEADBEEF, addr_error=0.
- Byte-lane store:
  - Pre-fill 0x80 with 0x11223344, then store 0xAABBCCDD with byte_en=4'b0101.
  - Load 0x80 returns 0x11BB33DD.
- Misaligned load to 0x42: resp_valid and addr_error high in the same cycle, resp_rdata=0. A misaligned store to 0x41 leaves word 0x40 unchanged.
- WAIT_CYCLES=0 back-to-back:
  - Each request gets resp_valid one cycle after accept; req_ready=0 in RESP; accepts are spaced every 2 cycles.
  - Wrap check with ADDR_WIDTH=10: a store to 0x1000 aliases word 0x0000.
- Reset mid-store: store 0x12345678 to 0x20, assert reset_n=0 during WAIT, release, load 0x20. Expect the prior contents and no resp_valid during reset.
